// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and a window-decode helper for the VGA timing generator.
package vga_timing_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Half-open window test lo <= pos < hi.
  function automatic logic in_window(input logic [9:0] pos, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo position counter for one screen axis; resets to its last position and also
// exposes the value it will take on the next edge so the top can register decodes in step.
module vga_axis_counter #(
  parameter int MODULUS = 800,
  parameter int WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] next_s;

  // Next position: step with wrap when enabled, otherwise hold.
  always_comb begin
    next_s = value_r;
    if (inc) begin
      if (value_r == MAX_C) begin
        next_s = ZERO_C;
      end else begin
        next_s = value_r + ONE_C;
      end
    end else begin
      next_s = value_r;
    end
  end

  // Position register; parking at MAX makes the first step after reset land on 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_r <= MAX_C;
    end else begin
      value_r <= next_s;
    end
  end

  assign value      = value_r;
  assign next_value = next_s;
  assign wrap       = (value_r == MAX_C);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: axis counters plus registered sync/display/strobe decode,
// all derived from next-state counters so every output describes the presented pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY  = DEF_H_DISPLAY,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_DISPLAY  = DEF_V_DISPLAY,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   FRAME_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_DISP_C   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_C   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START_C = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END_C   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START_C = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END_C   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [9:0] ZERO_C     = 10'd0;

  localparam logic [FRAME_W-1:0] FRAME_ONE_C = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_MAX_C = {FRAME_W{1'b1}};

  logic [9:0] h_next_s;
  logic [9:0] v_next_s;
  logic       h_wrap_s;
  logic       v_wrap_s;
  logic       v_inc_s;
  logic       frame_wrap_s;
  logic       display_s;
  logic       hsync_act_s;
  logic       vsync_act_s;

  logic               hsync_r;
  logic               vsync_r;
  logic               display_on_r;
  logic               line_start_r;
  logic               frame_start_r;
  logic [FRAME_W-1:0] frame_count_r;

  assign v_inc_s      = ce & h_wrap_s;
  assign frame_wrap_s = ce & h_wrap_s & v_wrap_s;

  vga_axis_counter #(.MODULUS(H_TOTAL), .WIDTH(10)) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (ce),
    .value      (hpos),
    .next_value (h_next_s),
    .wrap       (h_wrap_s)
  );

  vga_axis_counter #(.MODULUS(V_TOTAL), .WIDTH(10)) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (v_inc_s),
    .value      (vpos),
    .next_value (v_next_s),
    .wrap       (v_wrap_s)
  );

  // Window decode of the pixel about to be presented.
  always_comb begin
    display_s   = (h_next_s < H_DISP_C) && (v_next_s < V_DISP_C);
    hsync_act_s = in_window(h_next_s, HS_START_C, HS_END_C);
    vsync_act_s = in_window(v_next_s, VS_START_C, VS_END_C);
  end

  // Output registers; they move only with the counters so strobes last a whole pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_r       <= ~H_SYNC_POL;
      vsync_r       <= ~V_SYNC_POL;
      display_on_r  <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= FRAME_MAX_C;
    end else if (ce) begin
      hsync_r       <= hsync_act_s ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_r       <= vsync_act_s ? V_SYNC_POL : ~V_SYNC_POL;
      display_on_r  <= display_s;
      line_start_r  <= (h_next_s == ZERO_C);
      frame_start_r <= (h_next_s == ZERO_C) && (v_next_s == ZERO_C);
      if (frame_wrap_s) begin
        frame_count_r <= frame_count_r + FRAME_ONE_C;
      end
    end
  end

  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign display_on  = display_on_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed vector table on the 640x480 build, hand sequences for
// reset/ce/frame-wrap corners, and random ce/reset checked against a pixel-index model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       disp;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [9:0] fc;
  } obs_t;

  typedef struct {
    int   hd, hf, hs, hb, vd, vf, vs, vb, fw;
    logic hpol, vpol;
  } tim_t;

  typedef struct {
    logic rst_n;
    logic ce;
    int   n;
    obs_t exp;
  } vec_t;

  localparam tim_t T_DEF   = '{640, 16, 96, 48, 480, 10, 2, 33, 10, 1'b0, 1'b0};
  localparam tim_t T_SMALL = '{8, 2, 3, 2, 4, 1, 2, 1, 2, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic       d_hs, d_vs, d_disp, d_ls, d_fs;
  logic [9:0] d_h, d_v, d_fc;
  logic       s_hs, s_vs, s_disp, s_ls, s_fs;
  logic [9:0] s_h, s_v;
  logic [1:0] s_fc;

  int   tests_run = 0;
  int   fails = 0;
  int   p = -1;
  logic chk_en = 1'b0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(d_hs), .vsync(d_vs), .display_on(d_disp),
    .hpos(d_h), .vpos(d_v), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .FRAME_W(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(s_hs), .vsync(s_vs), .display_on(s_disp),
    .hpos(s_h), .vpos(s_v), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  obs_t act_def, act_small;
  assign act_def   = '{d_h, d_v, d_disp, d_hs, d_vs, d_ls, d_fs, d_fc};
  assign act_small = '{s_h, s_v, s_disp, s_hs, s_vs, s_ls, s_fs, {8'd0, s_fc}};

  // Reference: p = pixels presented since reset (-1 = parked reset state).
  function automatic obs_t model(input tim_t t, input int pix);
    int ht, vt, tot, k, f, hh, vv;
    logic act;
    obs_t o;
    ht  = t.hd + t.hf + t.hs + t.hb;
    vt  = t.vd + t.vf + t.vs + t.vb;
    tot = ht * vt;
    k   = ((pix % tot) + tot) % tot;
    f   = (pix + tot) / tot - 1;
    hh  = k % ht;
    vv  = k / ht;
    o.h    = 10'(hh);
    o.v    = 10'(vv);
    o.disp = (hh < t.hd) && (vv < t.vd);
    act    = (hh >= t.hd + t.hf) && (hh < t.hd + t.hf + t.hs);
    o.hs   = act ? t.hpol : ~t.hpol;
    act    = (vv >= t.vd + t.vf) && (vv < t.vd + t.vf + t.vs);
    o.vs   = act ? t.vpol : ~t.vpol;
    o.ls   = (pix >= 0) && (hh == 0);
    o.fs   = (pix >= 0) && (k == 0);
    o.fc   = 10'(f & ((1 << t.fw) - 1));
    return o;
  endfunction

  function automatic obs_t mk(input int h, input int v, input logic disp, input logic hs,
                              input logic vs, input logic ls, input logic fs, input int fc);
    obs_t o;
    o = '{10'(h), 10'(v), disp, hs, vs, ls, fs, 10'(fc)};
    return o;
  endfunction

  function automatic vec_t mkv(input logic r, input logic c, input int n, input obs_t e);
    vec_t x;
    x.rst_n = r;
    x.ce    = c;
    x.n     = n;
    x.exp   = e;
    return x;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got h=%0d v=%0d disp=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, need h=%0d v=%0d disp=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               name, $time, act.h, act.v, act.disp, act.hs, act.vs, act.ls, act.fs, act.fc,
               exp.h, exp.v, exp.disp, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic step(input logic r, input logic c);
    rst_n = r;
    ce    = c;
    @(posedge clk);
    #1;
  endtask

  // Track presented pixel index the way the spec defines it.
  always @(posedge clk) begin
    if (!rst_n) p <= -1;
    else if (ce) p <= p + 1;
  end

  // Every cycle, both builds must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("run_def", act_def, model(T_DEF, p));
      check("run_small", act_small, model(T_SMALL, p));
    end
  end

  initial begin
    int cnt;
    vecs[0]  = mkv(1'b0, 1'b1, 3,   mk(799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1023));
    vecs[1]  = mkv(1'b1, 1'b1, 1,   mk(0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));
    vecs[2]  = mkv(1'b1, 1'b0, 5,   mk(0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));
    vecs[3]  = mkv(1'b1, 1'b1, 655, mk(655, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    vecs[4]  = mkv(1'b1, 1'b1, 1,   mk(656, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    vecs[5]  = mkv(1'b1, 1'b1, 95,  mk(751, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    vecs[6]  = mkv(1'b1, 1'b1, 1,   mk(752, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    vecs[7]  = mkv(1'b1, 1'b1, 47,  mk(799, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    vecs[8]  = mkv(1'b1, 1'b1, 1,   mk(0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    vecs[9]  = mkv(1'b1, 1'b1, 639, mk(639, 1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    vecs[10] = mkv(1'b1, 1'b1, 1,   mk(640, 1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    vecs[11] = mkv(1'b0, 1'b0, 1,   mk(799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1023));
    vecs[12] = mkv(1'b1, 1'b0, 2,   mk(799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1023));
    vecs[13] = mkv(1'b1, 1'b1, 1,   mk(0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));

    step(1'b0, 1'b0);
    chk_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      for (int j = 0; j < vecs[i].n; j++) step(vecs[i].rst_n, vecs[i].ce);
      check($sformatf("vec%0d", i), act_def, vecs[i].exp);
    end

    // Mid-frame reset with ce high: syncs stay inactive, next edge is (0,0) of frame 0.
    for (int j = 0; j < 1100; j++) step(1'b1, 1'b1);
    check("pre_reset", act_def, mk(300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    step(1'b0, 1'b1);
    check("in_reset", act_def, mk(799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1023));
    step(1'b1, 1'b1);
    check("after_reset", act_def, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));

    // ce toggling: one line takes 1600 cycles, hsync low for 2x96 cycles.
    cnt = 0;
    for (int j = 0; j < 1600; j++) begin
      step(1'b1, (j % 2) == 1);
      if (d_hs == 1'b0) cnt++;
    end
    tests_run++;
    if (cnt != 192) begin
      fails++;
      $display("FAIL hsync_low_cycles: got %0d, need 192", cnt);
    end
    check("toggle_line_end", act_def, mk(0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0));

    // Small build frame counter: 120 pixels per frame, 2-bit counter wraps after 4 frames.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int j = 0; j < 120; j++) step(1'b1, 1'b1);
    check("small_frame1", act_small, mk(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1));
    for (int j = 0; j < 360; j++) step(1'b1, 1'b1);
    check("small_wrap", act_small, mk(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0));

    for (int j = 0; j < 20000; j++) begin
      step($urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
